// File: rtl/mc_control_fsm_pkg.sv
// Shared MIPS control definitions: opcodes, datapath select encodings and FSM state codes.
package mc_control_fsm_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [1:0] ALUSRCB_RT      = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR    = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM     = 2'b10;
    localparam logic [1:0] ALUSRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_MEMADR = 4'd2,
        ST_MEMRD  = 4'd3,
        ST_MEMWB  = 4'd4,
        ST_MEMWR  = 4'd5,
        ST_EXEC   = 4'd6,
        ST_ALUWB  = 4'd7,
        ST_ADDIEX = 4'd8,
        ST_ADDIWB = 4'd9,
        ST_BRANCH = 4'd10,
        ST_JUMP   = 4'd11,
        ST_HALT   = 4'd12
    } state_e;

    function automatic logic is_supported_op(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// Control/status bundle between the multi-cycle control FSM (master) and the datapath (slave).
interface mc_control_fsm_if;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pc_en;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       illegal;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, alu_op, pc_src, illegal
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, alu_op, pc_src, illegal
    );

endinterface

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS control unit: Moore decode of the registered state, with live zero for
// branches and mem_ready gating of the memory-access states.
module mc_control_fsm
    import mc_control_fsm_pkg::*;
#(
    parameter bit ILLEGAL_TO_FETCH = 1'b1,
    parameter bit MEM_WAIT_EN      = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    mc_control_fsm_if.master   bus,
    output logic [3:0]         state_o
);

    state_e     state_q;
    state_e     state_d;
    logic       mem_done_s;
    logic       pc_write_s;
    logic       branch_s;
    logic       iord_s;
    logic       mem_read_s;
    logic       mem_write_s;
    logic       ir_write_s;
    logic       reg_dst_s;
    logic       mem_to_reg_s;
    logic       reg_write_s;
    logic       alu_src_a_s;
    logic [1:0] alu_src_b_s;
    logic [1:0] alu_op_s;
    logic [1:0] pc_src_s;
    logic       illegal_s;

    assign mem_done_s = MEM_WAIT_EN ? bus.mem_ready : 1'b1;

    // State register with synchronous reset to FETCH.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; unused encodings recover to FETCH.
    always_comb begin
        state_d = ST_FETCH;
        case (state_q)
            ST_FETCH:  state_d = mem_done_s ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                case (bus.opcode)
                    OP_RTYPE: state_d = ST_EXEC;
                    OP_LW:    state_d = ST_MEMADR;
                    OP_SW:    state_d = ST_MEMADR;
                    OP_BEQ:   state_d = ST_BRANCH;
                    OP_ADDI:  state_d = ST_ADDIEX;
                    OP_J:     state_d = ST_JUMP;
                    default:  state_d = ILLEGAL_TO_FETCH ? ST_FETCH : ST_HALT;
                endcase
            end
            ST_MEMADR: state_d = (bus.opcode == OP_SW) ? ST_MEMWR : ST_MEMRD;
            ST_MEMRD:  state_d = mem_done_s ? ST_MEMWB : ST_MEMRD;
            ST_MEMWB:  state_d = ST_FETCH;
            ST_MEMWR:  state_d = mem_done_s ? ST_FETCH : ST_MEMWR;
            ST_EXEC:   state_d = ST_ALUWB;
            ST_ALUWB:  state_d = ST_FETCH;
            ST_ADDIEX: state_d = ST_ADDIWB;
            ST_ADDIWB: state_d = ST_FETCH;
            ST_BRANCH: state_d = ST_FETCH;
            ST_JUMP:   state_d = ST_FETCH;
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_FETCH;
        endcase
    end

    // Output decode; everything is forced low while reset is held.
    always_comb begin
        pc_write_s   = 1'b0;
        branch_s     = 1'b0;
        iord_s       = 1'b0;
        mem_read_s   = 1'b0;
        mem_write_s  = 1'b0;
        ir_write_s   = 1'b0;
        reg_dst_s    = 1'b0;
        mem_to_reg_s = 1'b0;
        reg_write_s  = 1'b0;
        alu_src_a_s  = 1'b0;
        alu_src_b_s  = ALUSRCB_RT;
        alu_op_s     = ALU_OP_ADD;
        pc_src_s     = PCSRC_ALU;
        illegal_s    = 1'b0;
        if (rst) begin
            pc_write_s = 1'b0;
            branch_s   = 1'b0;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    mem_read_s  = 1'b1;
                    alu_src_b_s = ALUSRCB_FOUR;
                    ir_write_s  = mem_done_s;
                    pc_write_s  = mem_done_s;
                end
                ST_DECODE: begin
                    alu_src_b_s = ALUSRCB_IMM_SH2;
                    illegal_s   = ~is_supported_op(bus.opcode);
                end
                ST_MEMADR: begin
                    alu_src_a_s = 1'b1;
                    alu_src_b_s = ALUSRCB_IMM;
                end
                ST_MEMRD: begin
                    iord_s     = 1'b1;
                    mem_read_s = 1'b1;
                end
                ST_MEMWB: begin
                    mem_to_reg_s = 1'b1;
                    reg_write_s  = 1'b1;
                end
                ST_MEMWR: begin
                    iord_s      = 1'b1;
                    mem_write_s = 1'b1;
                end
                ST_EXEC: begin
                    alu_src_a_s = 1'b1;
                    alu_op_s    = ALU_OP_FUNCT;
                end
                ST_ALUWB: begin
                    reg_dst_s   = 1'b1;
                    reg_write_s = 1'b1;
                end
                ST_ADDIEX: begin
                    alu_src_a_s = 1'b1;
                    alu_src_b_s = ALUSRCB_IMM;
                end
                ST_ADDIWB: reg_write_s = 1'b1;
                ST_BRANCH: begin
                    alu_src_a_s = 1'b1;
                    alu_op_s    = ALU_OP_SUB;
                    pc_src_s    = PCSRC_ALUOUT;
                    branch_s    = 1'b1;
                end
                ST_JUMP: begin
                    pc_src_s   = PCSRC_JUMP;
                    pc_write_s = 1'b1;
                end
                default: begin
                    pc_write_s = 1'b0;
                    branch_s   = 1'b0;
                end
            endcase
        end
    end

    assign bus.pc_en      = pc_write_s | (branch_s & bus.zero);
    assign bus.iord       = iord_s;
    assign bus.mem_read   = mem_read_s;
    assign bus.mem_write  = mem_write_s;
    assign bus.ir_write   = ir_write_s;
    assign bus.reg_dst    = reg_dst_s;
    assign bus.mem_to_reg = mem_to_reg_s;
    assign bus.reg_write  = reg_write_s;
    assign bus.alu_src_a  = alu_src_a_s;
    assign bus.alu_src_b  = alu_src_b_s;
    assign bus.alu_op     = alu_op_s;
    assign bus.pc_src     = pc_src_s;
    assign bus.illegal    = illegal_s;
    assign state_o        = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: per-cycle expected state and control vector are queued
// as stimulus is applied and compared against the DUT mid-cycle.
module tb_mc_control_fsm;
    import mc_control_fsm_pkg::*;

    typedef struct packed {
        logic       pc_en;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       illegal;
    } ctl_t;

    typedef struct {
        string      tag;
        logic       chk_st;
        logic [3:0] st;
        ctl_t       ctl;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] state_s;
    logic [3:0] state2_s;
    int         n_checks = 0;
    int         n_fail   = 0;
    exp_t       sb_q[$];

    mc_control_fsm_if mif ();
    mc_control_fsm_if mif2 ();

    mc_control_fsm #(.ILLEGAL_TO_FETCH(1'b1), .MEM_WAIT_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .bus(mif.master), .state_o(state_s)
    );

    mc_control_fsm #(.ILLEGAL_TO_FETCH(1'b0), .MEM_WAIT_EN(1'b0)) dut_halt (
        .clk(clk), .rst(rst), .bus(mif2.master), .state_o(state2_s)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h", tag, act, exp);
        end
    endtask

    function automatic ctl_t exp_ctl(input state_e s, input logic mr, input logic z,
                                     input logic [5:0] op);
        ctl_t c;
        c = '0;
        case (s)
            ST_FETCH:  begin c.mem_read = 1'b1; c.ir_write = mr; c.pc_en = mr; c.alu_src_b = 2'b01; end
            ST_DECODE: begin
                c.alu_src_b = 2'b11;
                c.illegal = !(op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010});
            end
            ST_MEMADR: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            ST_MEMRD:  begin c.iord = 1'b1; c.mem_read = 1'b1; end
            ST_MEMWB:  begin c.mem_to_reg = 1'b1; c.reg_write = 1'b1; end
            ST_MEMWR:  begin c.iord = 1'b1; c.mem_write = 1'b1; end
            ST_EXEC:   begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
            ST_ALUWB:  begin c.reg_dst = 1'b1; c.reg_write = 1'b1; end
            ST_ADDIEX: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            ST_ADDIWB: c.reg_write = 1'b1;
            ST_BRANCH: begin c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_src = 2'b01; c.pc_en = z; end
            ST_JUMP:   begin c.pc_src = 2'b10; c.pc_en = 1'b1; end
            default:   c = '0;
        endcase
        return c;
    endfunction

    function automatic ctl_t act_ctl(input logic sel2);
        ctl_t c;
        if (sel2)
            c = {mif2.pc_en, mif2.iord, mif2.mem_read, mif2.mem_write, mif2.ir_write, mif2.reg_dst,
                 mif2.mem_to_reg, mif2.reg_write, mif2.alu_src_a, mif2.alu_src_b, mif2.alu_op,
                 mif2.pc_src, mif2.illegal};
        else
            c = {mif.pc_en, mif.iord, mif.mem_read, mif.mem_write, mif.ir_write, mif.reg_dst,
                 mif.mem_to_reg, mif.reg_write, mif.alu_src_a, mif.alu_src_b, mif.alu_op,
                 mif.pc_src, mif.illegal};
        return c;
    endfunction

    // One clock: drive inputs, queue expectation, compare mid-cycle, advance past the edge.
    task automatic cyc(input string tag, input state_e s, input logic chk_st, input logic r,
                       input logic mr, input logic z);
        exp_t e;
        exp_t got;
        rst = r;
        mif.mem_ready = mr;
        mif.zero = z;
        e.tag = tag;
        e.chk_st = chk_st;
        e.st = s;
        e.ctl = r ? ctl_t'(16'h0000) : exp_ctl(s, mr, z, mif.opcode);
        sb_q.push_back(e);
        @(negedge clk);
        if (sb_q.size() == 0) begin
            check_eq({tag, "_sb_empty"}, 16'h0000, 16'h0001);
        end else begin
            got = sb_q.pop_front();
            if (got.chk_st) check_eq({got.tag, "_state"}, {12'h000, state_s}, {12'h000, got.st});
            check_eq({got.tag, "_ctl"}, act_ctl(1'b0), got.ctl);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_simple(input string tag, input logic [5:0] op, input logic [5:0] fn,
                              input state_e s2, input state_e s3, input int n, input logic z);
        mif.opcode = op;
        mif.funct = fn;
        cyc({tag, "_fetch"}, ST_FETCH, 1'b1, 1'b0, 1'b1, z);
        cyc({tag, "_decode"}, ST_DECODE, 1'b1, 1'b0, 1'b1, z);
        if (n > 2) cyc({tag, "_s2"}, s2, 1'b1, 1'b0, 1'b1, z);
        if (n > 3) cyc({tag, "_s3"}, s3, 1'b1, 1'b0, 1'b1, z);
    endtask

    // HALT-parked instance: illegal opcode, memory never ready (ignored in this configuration).
    initial begin
        mif2.opcode = 6'b111111;
        mif2.funct = 6'b000000;
        mif2.zero = 1'b0;
        mif2.mem_ready = 1'b0;
        @(negedge rst);
        for (int i = 0; i < 5; i++) begin
            state_e s;
            @(negedge clk);
            s = (i == 0) ? ST_FETCH : ((i == 1) ? ST_DECODE : ST_HALT);
            check_eq($sformatf("halt_c%0d_state", i), {12'h000, state2_s}, {12'h000, s});
            check_eq($sformatf("halt_c%0d_ctl", i), act_ctl(1'b1), exp_ctl(s, 1'b1, 1'b0, 6'b111111));
        end
    end

    initial begin
        mif.opcode = OP_RTYPE;
        mif.funct = 6'b100000;
        mif.zero = 1'b0;
        mif.mem_ready = 1'b1;
        cyc("rst0", ST_FETCH, 1'b0, 1'b1, 1'b1, 1'b0);
        cyc("rst1", ST_FETCH, 1'b1, 1'b1, 1'b1, 1'b0);

        run_simple("radd", OP_RTYPE, 6'b100000, ST_EXEC, ST_ALUWB, 4, 1'b0);
        run_simple("rsll", OP_RTYPE, 6'b000000, ST_EXEC, ST_ALUWB, 4, 1'b1);

        mif.opcode = OP_LW;
        cyc("lw_fetch", ST_FETCH, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc("lw_decode", ST_DECODE, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc("lw_memadr", ST_MEMADR, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cyc("lw_memrd_wait", ST_MEMRD, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("lw_memrd_done", ST_MEMRD, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc("lw_memwb", ST_MEMWB, 1'b1, 1'b0, 1'b1, 1'b0);

        mif.opcode = OP_SW;
        cyc("sw_fetch_wait", ST_FETCH, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("sw_fetch_wait", ST_FETCH, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("sw_fetch_done", ST_FETCH, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc("sw_decode", ST_DECODE, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc("sw_memadr", ST_MEMADR, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc("sw_memwr", ST_MEMWR, 1'b1, 1'b0, 1'b1, 1'b0);

        run_simple("beq_t", OP_BEQ, 6'b000000, ST_BRANCH, ST_FETCH, 3, 1'b1);
        run_simple("beq_nt", OP_BEQ, 6'b000000, ST_BRANCH, ST_FETCH, 3, 1'b0);
        run_simple("addi", OP_ADDI, 6'b000000, ST_ADDIEX, ST_ADDIWB, 4, 1'b0);
        run_simple("jump", OP_J, 6'b000000, ST_JUMP, ST_FETCH, 3, 1'b0);
        run_simple("ill", 6'b111111, 6'b000000, ST_FETCH, ST_FETCH, 2, 1'b0);

        mif.opcode = OP_SW;
        cyc("rstmid_fetch", ST_FETCH, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc("rstmid_decode", ST_DECODE, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc("rstmid_memadr", ST_MEMADR, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc("rstmid_memwr", ST_MEMWR, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("rstmid_rst", ST_MEMWR, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc("rstmid_after", ST_FETCH, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc("rstmid_decode2", ST_DECODE, 1'b1, 1'b0, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
